// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared FIFO widths and controller state encoding.
package fifo_ctrl_pkg;
  localparam int DIN_W  = 8;
  localparam int DOUT_W = 16;
  localparam int CNT_W  = 10;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BURST, ST_FLUSH} state_t;
endpackage

// File: rtl/fifo_ctrl_skid.sv
// fifo_ctrl_skid: 2-entry output buffer; head is always the oldest word.
module fifo_ctrl_skid
  import fifo_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DOUT_W-1:0] din,
  input  logic              pop,
  output logic              valid,
  output logic [DOUT_W-1:0] dout,
  output logic [1:0]        count
);
  logic [DOUT_W-1:0] head, tail;
  logic pop_v, head_ld, tail_ld;
  assign valid = count != 2'd0;
  assign dout = head;
  assign pop_v = pop & valid;
  assign head_ld = (push & (count == 2'd0 | (pop_v & count == 2'd1))) | (pop_v & count == 2'd2);
  assign tail_ld = push & ((count == 2'd2) | (count == 2'd1 & ~pop_v));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop_v);
      if (head_ld) head <= count == 2'd2 ? tail : din;
      if (tail_ld) tail <= din;
    end
endmodule

// File: rtl/fifo_burst_ctrl.sv
// fifo_burst_ctrl: byte writer and fixed-length burst reader around an 8-in/16-out FIFO.
module fifo_burst_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int BURST_LEN   = 16,
  parameter int SRST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_valid,
  input  logic [DIN_W-1:0]  src_data,
  input  logic              flush,
  output logic              fifo_srst,
  output logic              fifo_wr_en,
  output logic [DIN_W-1:0]  fifo_din,
  output logic              fifo_rd_en,
  input  logic [DOUT_W-1:0] fifo_dout,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_rd_data_count,
  output logic              m_valid,
  output logic [DOUT_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       burst_cnt,
  output logic              busy
);
  state_t state, state_nxt;
  logic [15:0] srst_cnt;
  logic [CNT_W-1:0] iss_cnt, acc_cnt;
  logic [1:0] skid_cnt;
  logic inflight, srst_done, live, abort, acc, last_acc;
  assign srst_done = srst_cnt == 16'(SRST_CYCLES - 1);
  assign live = state == ST_IDLE || state == ST_BURST;
  assign abort = flush & live;
  assign acc = m_valid & m_ready;
  assign last_acc = acc & m_last;
  assign fifo_din = src_data;
  assign m_last = m_valid & (acc_cnt == CNT_W'(BURST_LEN - 1));
  always_comb begin
    state_nxt = state;
    fifo_srst = state == ST_INIT || state == ST_FLUSH;
    fifo_wr_en = src_valid & ~fifo_full & live;
    fifo_rd_en = state == ST_BURST && !flush && !fifo_empty && iss_cnt < CNT_W'(BURST_LEN)
                 && (skid_cnt + 2'(inflight)) < 2'd2;
    busy = state != ST_IDLE;
    case (state)
      ST_INIT:  state_nxt = srst_done ? ST_IDLE : ST_INIT;
      ST_IDLE:  state_nxt = flush ? ST_FLUSH : fifo_rd_data_count >= CNT_W'(BURST_LEN) ? ST_BURST : ST_IDLE;
      ST_BURST: state_nxt = flush ? ST_FLUSH : last_acc ? ST_IDLE : ST_BURST;
      ST_FLUSH: state_nxt = srst_done ? ST_IDLE : ST_FLUSH;
      default:  state_nxt = ST_INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_INIT;
      srst_cnt <= '0;
      inflight <= 1'b0;
      iss_cnt <= '0;
      acc_cnt <= '0;
      drop_cnt <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      srst_cnt <= fifo_srst && !srst_done ? srst_cnt + 16'd1 : '0;
      inflight <= fifo_rd_en;
      iss_cnt <= state == ST_BURST ? iss_cnt + CNT_W'(fifo_rd_en) : '0;
      acc_cnt <= state == ST_BURST ? acc_cnt + CNT_W'(acc) : '0;
      drop_cnt <= src_valid && !fifo_wr_en && drop_cnt != 16'hFFFF ? drop_cnt + 16'd1 : drop_cnt;
      burst_cnt <= burst_cnt + 16'(last_acc);
    end
  fifo_ctrl_skid u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .push  (inflight),
    .din   (fifo_dout),
    .pop   (m_ready),
    .valid (m_valid),
    .dout  (m_data),
    .count (skid_cnt)
  );
endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// tb_fifo_burst_ctrl: directed stimulus, FIFO environment model and per-cycle stream scoreboard.
module tb_fifo_burst_ctrl;
  localparam int BL = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic src_valid = 1'b0;
  logic [7:0] src_data = 8'h00;
  logic flush = 1'b0;
  logic fifo_srst, fifo_wr_en, fifo_rd_en;
  logic [7:0] fifo_din;
  logic [15:0] fifo_dout = 16'h0;
  logic fifo_full = 1'b0;
  logic fifo_empty;
  logic [9:0] fifo_rd_data_count;
  logic m_valid, m_last;
  logic [15:0] m_data;
  logic m_ready = 1'b1;
  logic [15:0] drop_cnt, burst_cnt;
  logic busy;
  int n_cmp = 0;
  int n_err = 0;
  fifo_burst_ctrl #(.BURST_LEN(BL), .SRST_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data), .flush(flush),
    .fifo_srst(fifo_srst), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_rd_data_count(fifo_rd_data_count), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .drop_cnt(drop_cnt), .burst_cnt(burst_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // 8-in/16-out FIFO environment: first byte lands in the low half of the word.
  logic [7:0] mem [4096];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp - rp) < 2;
  assign fifo_rd_data_count = 10'((wp - rp) / 2);
  always @(posedge clk)
    if (fifo_srst) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (fifo_wr_en) begin
        mem[wp % 4096] <= fifo_din;
        wp <= wp + 1;
      end
      if (fifo_rd_en) begin
        fifo_dout <= {mem[(rp + 1) % 4096], mem[rp % 4096]};
        rp <= rp + 2;
      end
    end
  // m_ready pattern generator
  bit tog = 1'b0;
  bit rdy_lvl = 1'b1;
  bit [3:0] pat = 4'b1001;
  int ph = 0;
  always @(posedge clk) begin
    #1;
    m_ready = tog ? pat[ph] : rdy_lvl;
    ph = (ph + 1) % 4;
  end
  // Scoreboard: words read must come out once each, in order, with m_last every BL-th word.
  logic [15:0] rdq[$];
  logic [15:0] acc_log[$];
  int exp_skid = 0;
  int exp_inf = 0;
  int beat = 0;
  logic [15:0] exp_drop = 0;
  logic [15:0] exp_burst = 0;
  always @(negedge clk) begin
    bit exp_wr, acc, was_last;
    if (!rst_n) begin
      rdq.delete();
      exp_skid = 0;
      exp_inf = 0;
      beat = 0;
      exp_drop = 0;
      exp_burst = 0;
    end else begin
      exp_wr = src_valid && !fifo_full && !fifo_srst;
      chk("wr_en", fifo_wr_en, exp_wr);
      chk("din", fifo_din, src_data);
      chk("rd_during_srst", fifo_rd_en & fifo_srst, 0);
      if (fifo_rd_en) chk("rd_space", (exp_skid + exp_inf < 2) && !fifo_empty, 1);
      chk("m_valid", m_valid, exp_skid > 0);
      chk("m_last", m_last, exp_skid > 0 && beat == BL - 1);
      chk("drop_cnt", drop_cnt, exp_drop);
      chk("burst_cnt", burst_cnt, exp_burst);
      acc = exp_skid > 0 && m_ready;
      was_last = acc && beat == BL - 1;
      if (acc) begin
        if (rdq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL m_data: got %0h expected none at %0t", m_data, $time);
        end else begin
          chk("m_data", m_data, rdq[0]);
          void'(rdq.pop_front());
        end
        acc_log.push_back(m_data);
      end
      if (flush && !fifo_srst) begin
        rdq.delete();
        exp_skid = 0;
        exp_inf = 0;
        beat = 0;
      end else begin
        if (acc) beat = was_last ? 0 : beat + 1;
        exp_skid = exp_skid - int'(acc) + exp_inf;
        exp_inf = int'(fifo_rd_en);
        if (fifo_rd_en) rdq.push_back({mem[(rp + 1) % 4096], mem[rp % 4096]});
      end
      if (was_last) exp_burst++;
      if (src_valid && !exp_wr && exp_drop != 16'hFFFF) exp_drop++;
    end
  end
  int nb = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put_bytes(int n);
    for (int i = 0; i < n; i++) begin
      tick();
      src_valid = 1'b1;
      src_data = nb[7:0];
      nb++;
    end
    tick();
    src_valid = 1'b0;
  endtask
  task automatic wait_burst(logic [15:0] target);
    for (int i = 0; i < 400 && burst_cnt != target; i++) @(negedge clk);
    chk("burst_done", burst_cnt, target);
  endtask
  task automatic count_srst(string name);
    int k = 0;
    for (int i = 0; i < 20 && fifo_srst; i++) begin
      k++;
      @(negedge clk);
    end
    chk(name, k, 4);
    chk({name, "_busy"}, busy, 0);
  endtask
  initial begin
    int base;
    repeat (2) @(negedge clk);
    chk("rst_srst", fifo_srst, 1);
    chk("rst_wr", fifo_wr_en, 0);
    chk("rst_rd", fifo_rd_en, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mlast", m_last, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_burst", burst_cnt, 0);
    chk("rst_busy", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    count_srst("init_srst_len");
    // one burst out of 20 words, sink always ready
    put_bytes(40);
    wait_burst(16'd1);
    repeat (3) @(negedge clk);
    chk("b1_busy", busy, 0);
    chk("b1_words", acc_log.size(), 16);
    chk("b1_first", acc_log[0], 16'h0100);
    chk("b1_last", acc_log[15], 16'h1F1E);
    chk("b1_remain", fifo_rd_data_count, 4);
    // stalling sink 1,0,0,1
    tog = 1'b1;
    put_bytes(24);
    wait_burst(16'd2);
    tog = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2_words", acc_log.size(), 32);
    chk("b2_first", acc_log[16], 16'h2120);
    chk("b2_last", acc_log[31], 16'h3F3E);
    chk("b2_remain", fifo_rd_data_count, 0);
    chk("b2_busy", busy, 0);
    // FIFO full: every byte dropped
    for (int i = 0; i < 10; i++) begin
      tick();
      fifo_full = 1'b1;
      src_valid = 1'b1;
      src_data = 8'hEE;
    end
    tick();
    fifo_full = 1'b0;
    src_valid = 1'b0;
    @(negedge clk);
    chk("drop10", drop_cnt, 10);
    // flush in the middle of a burst
    put_bytes(32);
    for (int i = 0; i < 200 && acc_log.size() < 36; i++) @(posedge clk);
    chk("b3_reached", acc_log.size() >= 36, 1);
    #1 flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_mvalid", m_valid, 0);
    count_srst("flush_srst_len");
    chk("flush_burst_cnt", burst_cnt, 2);
    chk("flush_fifo_cnt", fifo_rd_data_count, 0);
    // recovery burst after flush
    base = acc_log.size();
    put_bytes(32);
    wait_burst(16'd3);
    chk("b4_first", acc_log[base], 16'h6160);
    chk("b4_last", acc_log[base + 15], 16'h7F7E);
    // saturate drop counter
    tick();
    fifo_full = 1'b1;
    src_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    fifo_full = 1'b0;
    src_valid = 1'b0;
    @(negedge clk);
    chk("drop_sat", drop_cnt, 16'hFFFF);
    chk("drop_sat_burst", burst_cnt, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
